// File: rtl/intr_reset_sequencer.sv
// Start-up and interrupt entry/exit sequencer for the decode/control stage.
// Build option: define INTR_EDGE_DETECT_EN to take interrupts on a rising edge of intr_in instead of its level.
module intr_reset_sequencer #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned FLAG_W         = 4,
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter int unsigned RESET_VEC_ADDR = 0,
    parameter int unsigned INTR_VEC_ADDR  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_in,
    input  logic              rti_retire,
    input  logic              branch_pending,
    input  logic [DATA_W-1:0] pc_resume,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sp_dec,
    output logic              stall_fetch,
    output logic              flush,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_load_val,
    output logic              flags_restore,
    output logic [FLAG_W-1:0] flags_out,
    output logic              in_isr,
    output logic              busy
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {RVEC, RWAIT, IDLE, DRAIN, PUSH, VEC, VWAIT} state_t;

    state_t           state, state_nx;
    logic             pending;
    logic             intr_hit;
    logic             push_done;
    logic [CNT_W-1:0] counter;

`ifdef INTR_EDGE_DETECT_EN
    logic intr_in_d;

    // Reset to 1 so a request already high when reset releases is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) intr_in_d <= 1'b1;
        else     intr_in_d <= intr_in;
    end

    assign intr_hit = intr_in & ~intr_in_d;
`else
    assign intr_hit = intr_in;
`endif

    assign push_done = (state == PUSH) && mem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RVEC;
            pending       <= 1'b0;
            in_isr        <= 1'b0;
            counter       <= '0;
            flags_out     <= '0;
            flags_restore <= 1'b0;
        end else begin
            state         <= state_nx;
            // A new request arriving in the push-grant cycle wins over the clear.
            pending       <= (pending & ~push_done) | intr_hit;
            flags_restore <= rti_retire & in_isr;
            if (rti_retire && in_isr)
                in_isr <= 1'b0;
            else if (state == VWAIT)
                in_isr <= 1'b1;
            if (push_done)
                flags_out <= flags_in;
            if (state == IDLE && state_nx == DRAIN)
                counter <= CNT_W'(DRAIN_CYCLES);
            else if (state == DRAIN && counter != '0)
                counter <= counter - CNT_W'(1);
        end
    end

    always_comb begin
        state_nx    = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        sp_dec      = 1'b0;
        stall_fetch = 1'b0;
        flush       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        busy        = 1'b0;

        case (state)
            RVEC: begin
                mem_req     = 1'b1;
                mem_addr    = ADDR_W'(RESET_VEC_ADDR);
                stall_fetch = 1'b1;
                busy        = 1'b1;
                if (mem_gnt) state_nx = RWAIT;
            end
            RWAIT: begin
                pc_load     = 1'b1;
                pc_load_val = mem_rdata;
                stall_fetch = 1'b1;
                busy        = 1'b1;
                state_nx    = IDLE;
            end
            IDLE: begin
                if (pending && !in_isr) begin
                    flush       = 1'b1;
                    stall_fetch = 1'b1;
                    busy        = 1'b1;
                    state_nx    = DRAIN;
                end
            end
            DRAIN: begin
                stall_fetch = 1'b1;
                busy        = 1'b1;
                if (counter == '0 && !branch_pending) state_nx = PUSH;
            end
            PUSH: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp_in;
                mem_wdata   = pc_resume;
                stall_fetch = 1'b1;
                busy        = 1'b1;
                if (mem_gnt) begin
                    sp_dec   = 1'b1;
                    state_nx = VEC;
                end
            end
            VEC: begin
                mem_req     = 1'b1;
                mem_addr    = ADDR_W'(INTR_VEC_ADDR);
                stall_fetch = 1'b1;
                busy        = 1'b1;
                if (mem_gnt) state_nx = VWAIT;
            end
            VWAIT: begin
                pc_load     = 1'b1;
                pc_load_val = mem_rdata;
                stall_fetch = 1'b1;
                busy        = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = RVEC;
        endcase

        // Reset held high: keep the core frozen and the memory port released.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            sp_dec      = 1'b0;
            flush       = 1'b0;
            pc_load     = 1'b0;
            stall_fetch = 1'b1;
            busy        = 1'b1;
        end
    end

endmodule

// File: tb/tb_intr_reset_sequencer.sv
// Directed bench for intr_reset_sequencer: boot vector, interrupt entry, drain, grant stall, RTI and re-entry.
module tb_intr_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr_in;
    logic       rti_retire;
    logic       branch_pending;
    logic [7:0] pc_resume;
    logic [7:0] sp_in;
    logic [3:0] flags_in;
    logic       mem_gnt;
    logic [7:0] mem_rdata;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       sp_dec;
    logic       stall_fetch;
    logic       flush;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       flags_restore;
    logic [3:0] flags_out;
    logic       in_isr;
    logic       busy;

    logic [7:0] mem [0:255];
    int         checks = 0;
    int         errors = 0;

`ifdef INTR_EDGE_DETECT_EN
    localparam logic LEVEL = 1'b0;
`else
    localparam logic LEVEL = 1'b1;
`endif

    intr_reset_sequencer #(
        .ADDR_W(8), .DATA_W(8), .FLAG_W(4), .DRAIN_CYCLES(3),
        .RESET_VEC_ADDR(0), .INTR_VEC_ADDR(1)
    ) dut (
        .clk(clk), .rst(rst), .intr_in(intr_in), .rti_retire(rti_retire),
        .branch_pending(branch_pending), .pc_resume(pc_resume), .sp_in(sp_in),
        .flags_in(flags_in), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp_dec(sp_dec), .stall_fetch(stall_fetch), .flush(flush), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .flags_restore(flags_restore), .flags_out(flags_out),
        .in_isr(in_isr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Data memory: read data appears one cycle after a granted read.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h20;
        mem[1] = 8'h80;
        mem_rdata = 8'h00;
        rst = 1'b1; intr_in = 1'b0; rti_retire = 1'b0; branch_pending = 1'b0;
        pc_resume = 8'h34; sp_in = 8'hFF; flags_in = 4'b1010; mem_gnt = 1'b1;

        repeat (3) tick();
        chk("rst_busy",    32'(busy), 1);
        chk("rst_stall",   32'(stall_fetch), 1);
        chk("rst_req",     32'(mem_req), 0);
        chk("rst_pcload",  32'(pc_load), 0);
        chk("rst_isr",     32'(in_isr), 0);
        chk("rst_flags",   32'(flags_out), 0);
        chk("rst_restore", 32'(flags_restore), 0);

        rst = 1'b0; #1;
        chk("boot_req",  32'(mem_req), 1);
        chk("boot_we",   32'(mem_we), 0);
        chk("boot_addr", 32'(mem_addr), 32'h00);
        tick();
        chk("boot_pcload", 32'(pc_load), 1);
        chk("boot_pcval",  32'(pc_load_val), 32'h20);
        chk("boot_stall",  32'(stall_fetch), 1);
        tick();
        chk("idle_stall",  32'(stall_fetch), 0);
        chk("idle_busy",   32'(busy), 0);
        chk("idle_pcload", 32'(pc_load), 0);
        chk("idle_req",    32'(mem_req), 0);

        rti_retire = 1'b1; tick(); rti_retire = 1'b0; #1;
        chk("rti_ignored", 32'(flags_restore), 0);
        chk("rti_ign_isr", 32'(in_isr), 0);

        intr_in = 1'b1; tick(); intr_in = 1'b0; #1;
        chk("ent_flush", 32'(flush), 1);
        chk("ent_stall", 32'(stall_fetch), 1);
        chk("ent_req",   32'(mem_req), 0);
        tick();
        chk("ent_flush_once", 32'(flush), 0);
        chk("drain_stall",    32'(stall_fetch), 1);
        repeat (3) tick();
        chk("drain_noreq", 32'(mem_req), 0);
        tick();
        chk("push_req",   32'(mem_req), 1);
        chk("push_we",    32'(mem_we), 1);
        chk("push_addr",  32'(mem_addr), 32'hFF);
        chk("push_wdata", 32'(mem_wdata), 32'h34);
        chk("push_spdec", 32'(sp_dec), 1);
        tick();
        chk("vec_req",    32'(mem_req), 1);
        chk("vec_we",     32'(mem_we), 0);
        chk("vec_addr",   32'(mem_addr), 32'h01);
        chk("vec_spdec",  32'(sp_dec), 0);
        chk("vec_flags",  32'(flags_out), 32'hA);
        chk("vec_pcload", 32'(pc_load), 0);
        tick();
        chk("vw_pcload", 32'(pc_load), 1);
        chk("vw_pcval",  32'(pc_load_val), 32'h80);
        tick();
        chk("isr_on",    32'(in_isr), 1);
        chk("isr_stall", 32'(stall_fetch), 0);
        chk("isr_busy",  32'(busy), 0);
        chk("push_mem",  32'(mem[8'hFF]), 32'h34);

        rti_retire = 1'b1; intr_in = 1'b1; #1;
        chk("co_no_early_restore", 32'(flags_restore), 0);
        chk("co_no_nest_flush",    32'(flush), 0);
        tick();
        rti_retire = 1'b0; intr_in = 1'b0;
        pc_resume = 8'h40; sp_in = 8'hFE; flags_in = 4'b0101; #1;
        chk("co_restore", 32'(flags_restore), 1);
        chk("co_isr_off", 32'(in_isr), 0);
        chk("co_flags",   32'(flags_out), 32'hA);
        chk("co_flush",   32'(flush), 1);
        tick();
        chk("co_restore_once", 32'(flags_restore), 0);
        chk("co_drain_stall",  32'(stall_fetch), 1);
        chk("co_flush_once",   32'(flush), 0);
        repeat (2) tick();
        branch_pending = 1'b1;
        intr_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("br_hold_req",   32'(mem_req), 0);
            chk("br_hold_stall", 32'(stall_fetch), 1);
        end
        branch_pending = 1'b0; pc_resume = 8'h50; mem_gnt = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("gs_req",   32'(mem_req), 1);
            chk("gs_we",    32'(mem_we), 1);
            chk("gs_addr",  32'(mem_addr), 32'hFE);
            chk("gs_wdata", 32'(mem_wdata), 32'h50);
            chk("gs_spdec", 32'(sp_dec), 0);
        end
        mem_gnt = 1'b1; #1;
        chk("gs_grant_spdec", 32'(sp_dec), 1);
        chk("gs_grant_wdata", 32'(mem_wdata), 32'h50);
        tick();
        chk("gs_vec_spdec", 32'(sp_dec), 0);
        chk("gs_vec_addr",  32'(mem_addr), 32'h01);
        chk("gs_flags",     32'(flags_out), 32'h5);
        tick();
        chk("gs_pcload", 32'(pc_load), 1);
        chk("gs_pcval",  32'(pc_load_val), 32'h80);
        tick();
        chk("gs_isr_on", 32'(in_isr), 1);
        chk("br_mem",    32'(mem[8'hFE]), 32'h50);
        tick();
        chk("nest_noflush", 32'(flush), 0);
        chk("nest_idle",    32'(stall_fetch), 0);

        rti_retire = 1'b1; tick(); rti_retire = 1'b0; #1;
        chk("lv_restore", 32'(flags_restore), 1);
        chk("lv_isr_off", 32'(in_isr), 0);
        chk("lv_flags",   32'(flags_out), 32'h5);
        chk("lv_flush",   32'(flush), 32'(LEVEL));
        tick();
        chk("lv_stall",   32'(stall_fetch), 32'(LEVEL));
        chk("lv_flush_once", 32'(flush), 0);
        intr_in = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
